// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, owner tags and counter widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT_RSP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } arb_owner_e;

    // Wide enough for STARVE_MAX up to 15.
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access; data wins, fetch has a starvation guard.
// Latency: requests pass combinationally to memory in IDLE; responses pass through the same cycle (0 added cycles).
// Backpressure: one outstanding transaction; x_req_ready only in IDLE for the selected requester with mem_req_ready.
//
// Ports:
//   clock, reset                      rising-edge clock, asynchronous active-high reset
//   if_req_* / if_rsp_*               fetch request (valid/addr/ready) and response (valid/rdata)
//   d_req_* / d_rsp_*                 data request (valid/we/addr/wdata/be/ready) and response (valid/rdata)
//   mem_req_* / mem_rsp_*             shared backing memory port
//   perf_if_gnt/perf_d_gnt/perf_conflict
//                                     32-bit wrapping event counters, present only when
//                                     MEM_ARB_PERF_EN is defined
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_rdata,

    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_be,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_rdata,

    output logic                mem_req_valid,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_be,
    input  logic                mem_req_ready,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_if_gnt,
    output logic [31:0]         perf_d_gnt,
    output logic [31:0]         perf_conflict
`endif
);

    localparam int BE_W = DATA_W / 8;

    arb_state_e              state;
    arb_owner_e              owner;
    logic                    we_q;
    logic [STARVE_CNT_W-1:0] starve_cnt;

    logic idle;
    logic starved;
    logic sel_if;
    logic sel_d;
    logic accept;
    logic rsp_hit;

    // Reset gates the request side so every output reads 0 while reset is held,
    // even if requesters keep their valids up.
    assign idle    = (state == ARB_IDLE) && !reset;
    assign starved = (starve_cnt == STARVE_CNT_W'(STARVE_MAX));

    // Data normally wins; a starved fetch overrides it.
    assign sel_if  = if_req_valid && (!d_req_valid || starved);
    assign sel_d   = d_req_valid && !sel_if;

    assign mem_req_valid = idle && (sel_if || sel_d);
    assign accept        = mem_req_valid && mem_req_ready;

    assign if_req_ready  = idle && sel_if && mem_req_ready;
    assign d_req_ready   = idle && sel_d  && mem_req_ready;

    always_comb begin
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_be    = '0;
        if (idle && sel_d) begin
            mem_req_we    = d_req_we;
            mem_req_addr  = d_req_addr;
            mem_req_wdata = d_req_wdata;
            mem_req_be    = d_req_be;
        end else if (idle && sel_if) begin
            mem_req_addr  = if_req_addr;
            mem_req_be    = {BE_W{1'b1}};
        end
    end

    // Responses in IDLE (e.g. a late reply to a transaction dropped by reset) are ignored.
    assign rsp_hit      = (state == ARB_WAIT_RSP) && mem_rsp_valid;
    assign if_rsp_valid = rsp_hit && (owner == OWN_IF);
    assign d_rsp_valid  = rsp_hit && (owner == OWN_D);
    assign if_rsp_rdata = if_rsp_valid ? mem_rsp_rdata : '0;
    assign d_rsp_rdata  = (d_rsp_valid && !we_q) ? mem_rsp_rdata : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= OWN_IF;
            we_q       <= 1'b0;
            starve_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        state <= ARB_WAIT_RSP;
                        owner <= sel_d ? OWN_D : OWN_IF;
                        we_q  <= sel_d && d_req_we;
                        if (sel_if) begin
                            starve_cnt <= '0;
                        end else if (if_req_valid && !starved) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                ARB_WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_if_gnt   <= '0;
            perf_d_gnt    <= '0;
            perf_conflict <= '0;
        end else begin
            if (if_req_ready) begin
                perf_if_gnt <= perf_if_gnt + 32'd1;
            end
            if (d_req_ready) begin
                perf_d_gnt <= perf_d_gnt + 32'd1;
            end
            if (idle && if_req_valid && d_req_valid) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: vector table for IDLE arbitration plus directed multi-cycle sequences.
// Latency: behavioural memory model with programmable response latency.
// Backpressure: mem_req_ready driven per vector; responses checked through an in-order scoreboard.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_rdata;
    logic        d_req_valid;
    logic        d_req_we;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_be;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_gnt;
    logic [31:0] perf_d_gnt;
    logic [31:0] perf_conflict;
`endif

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_rsp_valid  (if_rsp_valid),
        .if_rsp_rdata  (if_rsp_rdata),
        .d_req_valid   (d_req_valid),
        .d_req_we      (d_req_we),
        .d_req_addr    (d_req_addr),
        .d_req_wdata   (d_req_wdata),
        .d_req_be      (d_req_be),
        .d_req_ready   (d_req_ready),
        .d_rsp_valid   (d_rsp_valid),
        .d_rsp_rdata   (d_rsp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_be    (mem_req_be),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_gnt   (perf_if_gnt),
        .perf_d_gnt    (perf_d_gnt),
        .perf_conflict (perf_conflict)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
    } rsp_t;
    rsp_t sb[$];

    task automatic push_rsp(input logic is_d, input logic [31:0] rdata);
        rsp_t r;
        r.is_d  = is_d;
        r.rdata = rdata;
        sb.push_back(r);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (if_rsp_valid || d_rsp_valid) begin
                chk("rsp_both_valid", 32'(if_rsp_valid && d_rsp_valid), 32'd0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got if=%0d d=%0d, required no response at %0t",
                             if_rsp_valid, d_rsp_valid, $time);
                end else begin
                    rsp_t e;
                    e = sb.pop_front();
                    chk("rsp_port", 32'(d_rsp_valid), 32'(e.is_d));
                    chk("rsp_rdata", d_rsp_valid ? d_rsp_rdata : if_rsp_rdata, e.rdata);
                end
            end
        end
    end

    // ---------------- memory model ----------------
    logic [31:0] mem [0:255];
    int          lat  = 2;
    bit          busy = 1'b0;
    int          cnt;
    logic        p_we;
    logic [31:0] p_addr;

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h0000_0083 : (32'h1000_0000 + 32'(i));
    endfunction

    task automatic respond();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = p_we ? 32'hDEAD_BEEF : mem[p_addr[9:2]];
        busy          = 1'b0;
    endtask

    initial begin
        logic        acc;
        logic        a_we;
        logic [31:0] a_addr;
        logic [31:0] a_wdata;
        logic [3:0]  a_be;
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        forever begin
            @(negedge clock);
            acc     = mem_req_valid && mem_req_ready;
            a_we    = mem_req_we;
            a_addr  = mem_req_addr;
            a_wdata = mem_req_wdata;
            a_be    = mem_req_be;
            @(posedge clock);
            #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = '0;
            if (busy) begin
                cnt--;
                if (cnt <= 0) respond();
            end
            if (acc) begin
                busy   = 1'b1;
                p_we   = a_we;
                p_addr = a_addr;
                if (a_we) begin
                    for (int b = 0; b < 4; b++)
                        if (a_be[b]) mem[a_addr[9:2]][8*b +: 8] = a_wdata[8*b +: 8];
                end
                cnt = lat - 1;
                if (cnt <= 0) respond();
            end
        end
    end

    task automatic drain();
        int c;
        c = 0;
        while ((sb.size() != 0 || busy) && c < 60) begin
            next_cycle();
            c++;
        end
        if (c >= 60) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d responses pending, required 0", sb.size());
        end
        next_cycle();
        next_cycle();
    endtask

    task automatic idle_inputs();
        if_req_valid  = 1'b0;
        if_req_addr   = '0;
        d_req_valid   = 1'b0;
        d_req_we      = 1'b0;
        d_req_addr    = '0;
        d_req_wdata   = '0;
        d_req_be      = '0;
        mem_req_ready = 1'b1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_rdy"},  32'(if_req_ready),  32'd0);
        chk({tag, "_d_rdy"},   32'(d_req_ready),   32'd0);
        chk({tag, "_if_rspv"}, 32'(if_rsp_valid),  32'd0);
        chk({tag, "_d_rspv"},  32'(d_rsp_valid),   32'd0);
        chk({tag, "_if_rd"},   if_rsp_rdata,       32'd0);
        chk({tag, "_d_rd"},    d_rsp_rdata,        32'd0);
        chk({tag, "_mv"},      32'(mem_req_valid), 32'd0);
        chk({tag, "_mwe"},     32'(mem_req_we),    32'd0);
        chk({tag, "_maddr"},   mem_req_addr,       32'd0);
        chk({tag, "_mwd"},     mem_req_wdata,      32'd0);
        chk({tag, "_mbe"},     32'(mem_req_be),    32'd0);
    endtask

    // IF and a D byte load in the same cycle: D first, IF the cycle after D's response.
    task automatic run_scn2();
        lat = 2;
        if_req_valid = 1'b1; if_req_addr = 32'h8;
        d_req_valid  = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h0; d_req_be = 4'b0001;
        push_rsp(1'b1, 32'h0000_0083);
        push_rsp(1'b0, init_word(2));
        @(negedge clock);
        chk("s2_c0_d_rdy",  32'(d_req_ready),  32'd1);
        chk("s2_c0_if_rdy", 32'(if_req_ready), 32'd0);
        chk("s2_c0_be",     32'(mem_req_be),   32'h1);
        next_cycle();
        d_req_valid = 1'b0;
        @(negedge clock);
        chk("s2_c1_if_rdy", 32'(if_req_ready), 32'd0);
        next_cycle();
        @(negedge clock);
        chk("s2_c2_d_rspv", 32'(d_rsp_valid),  32'd1);
        chk("s2_c2_if_rdy", 32'(if_req_ready), 32'd0);
        next_cycle();
        @(negedge clock);
        chk("s2_c3_if_rdy", 32'(if_req_ready), 32'd1);
        next_cycle();
        if_req_valid = 1'b0;
        drain();
    endtask

    typedef struct {
        logic        ifv, dv, dwe, rdy;
        logic        e_ifr, e_dr, e_mv, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic [31:0] e_rsp;
    } vec_t;

    vec_t vt[7];

    initial begin
        int          ng;
        logic        gnt  [6];
        int          gcyc [6];
        logic        exp_g[6];

        vt[0] = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 32'h0,   32'h0,         4'h0, 32'h0};
        vt[1] = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0, 32'h100, 32'h0,         4'hF, 32'h1000_0040};
        vt[2] = '{1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b0, 32'h200, 32'hA5A5_5A5A, 4'h3, 32'h1000_0080};
        vt[3] = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b1, 32'h200, 32'hA5A5_5A5A, 4'h3, 32'h0};
        vt[4] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 32'h200, 32'hA5A5_5A5A, 4'h3, 32'h0};
        vt[5] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, 32'h100, 32'h0,         4'hF, 32'h0};
        vt[6] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1, 32'h200, 32'hA5A5_5A5A, 4'h3, 32'h0};

        // Reset with both requesters active: every output must read 0.
        idle_inputs();
        reset = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 32'h40;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h44; d_req_wdata = 32'h1234_5678; d_req_be = 4'hF;
        @(negedge clock);
        chk_all_zero("rst");
        next_cycle();
        idle_inputs();
        reset = 1'b0;
        next_cycle();

        // Fetch only, latency 2.
        lat = 2;
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        push_rsp(1'b0, 32'h0000_0083);
        @(negedge clock);
        chk("s1_c0_if_rdy", 32'(if_req_ready), 32'd1);
        chk("s1_c0_be",     32'(mem_req_be),   32'hF);
        next_cycle();
        if_req_valid = 1'b0;
        @(negedge clock);
        chk("s1_c1_if_rspv", 32'(if_rsp_valid), 32'd0);
        next_cycle();
        @(negedge clock);
        chk("s1_c2_if_rspv", 32'(if_rsp_valid), 32'd1);
        chk("s1_c2_if_rd",   if_rsp_rdata,       32'h0000_0083);
        next_cycle();
        drain();

        run_scn2();

        // Byte store, then read back to see the byte enable honoured.
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h4; d_req_wdata = 32'h0000_00FF; d_req_be = 4'b0001;
        push_rsp(1'b1, 32'h0);
        @(negedge clock);
        chk("s3_d_rdy", 32'(d_req_ready), 32'd1);
        chk("s3_we",    32'(mem_req_we),  32'd1);
        chk("s3_be",    32'(mem_req_be),  32'h1);
        chk("s3_wdata", mem_req_wdata,    32'h0000_00FF);
        chk("s3_addr",  mem_req_addr,     32'h4);
        next_cycle();
        d_req_valid = 1'b0;
        drain();
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h4; d_req_be = 4'hF;
        push_rsp(1'b1, 32'h1000_00FF);
        @(negedge clock);
        chk("s3_ld_rdy", 32'(d_req_ready), 32'd1);
        next_cycle();
        d_req_valid = 1'b0;
        drain();

        // Starvation guard: continuous D with IF pending.
        lat = 1;
        exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) push_rsp(exp_g[k], exp_g[k] ? init_word(4) : init_word(8));
        if_req_valid = 1'b1; if_req_addr = 32'h20;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h10; d_req_be = 4'hF;
        ng = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            @(negedge clock);
            if (if_req_ready || d_req_ready) begin
                gnt[ng]  = d_req_ready;
                gcyc[ng] = c;
                ng++;
            end
            next_cycle();
            if (ng >= 5) if_req_valid = 1'b0;
            if (ng >= 6) d_req_valid = 1'b0;
        end
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        chk("s4_grants", 32'(ng), 32'd6);
        for (int k = 0; k < ng; k++) chk($sformatf("s4_gnt%0d_is_d", k), 32'(gnt[k]), 32'(exp_g[k]));
        if (ng >= 2) chk("s4_gap", 32'(gcyc[1] - gcyc[0]), 32'd2);
        drain();

        // Reset during WAIT_RSP; the memory's late reply must be ignored.
        lat = 4;
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        @(negedge clock);
        chk("s5_c0_if_rdy", 32'(if_req_ready), 32'd1);
        next_cycle();
        if_req_valid = 1'b0;
        next_cycle();
        reset = 1'b1;
        if_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b1; d_req_wdata = 32'hFFFF_FFFF; d_req_be = 4'hF;
        @(negedge clock);
        chk_all_zero("s5_rst");
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        next_cycle();
        @(negedge clock);
        chk("s5_late_mrsp", 32'(mem_rsp_valid), 32'd1);
        chk("s5_late_if",   32'(if_rsp_valid),  32'd0);
        chk("s5_late_d",    32'(d_rsp_valid),   32'd0);
        next_cycle();
        lat = 1;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h10; d_req_be = 4'hF;
        push_rsp(1'b1, init_word(4));
        @(negedge clock);
        chk("s5_next_d_rdy", 32'(d_req_ready), 32'd1);
        next_cycle();
        d_req_valid = 1'b0;
        drain();

        // Vector table: single-cycle arbitration decisions from a fresh reset.
        for (int v = 0; v < 7; v++) begin
            pulse_reset();
            lat = 1;
            if_req_valid = vt[v].ifv; if_req_addr = 32'h100;
            d_req_valid = vt[v].dv; d_req_we = vt[v].dwe; d_req_addr = 32'h200;
            d_req_wdata = 32'hA5A5_5A5A; d_req_be = 4'h3;
            mem_req_ready = vt[v].rdy;
            if (vt[v].e_ifr) push_rsp(1'b0, vt[v].e_rsp);
            if (vt[v].e_dr)  push_rsp(1'b1, vt[v].e_rsp);
            @(negedge clock);
            chk($sformatf("v%0d_if_rdy", v), 32'(if_req_ready),  32'(vt[v].e_ifr));
            chk($sformatf("v%0d_d_rdy", v),  32'(d_req_ready),   32'(vt[v].e_dr));
            chk($sformatf("v%0d_mv", v),     32'(mem_req_valid), 32'(vt[v].e_mv));
            chk($sformatf("v%0d_we", v),     32'(mem_req_we),    32'(vt[v].e_we));
            chk($sformatf("v%0d_addr", v),   mem_req_addr,       vt[v].e_addr);
            chk($sformatf("v%0d_wdata", v),  mem_req_wdata,      vt[v].e_wdata);
            chk($sformatf("v%0d_be", v),     32'(mem_req_be),    32'(vt[v].e_be));
            next_cycle();
            idle_inputs();
            drain();
        end

`ifdef MEM_ARB_PERF_EN
        pulse_reset();
        chk("perf_rst_if", perf_if_gnt, 32'd0);
        run_scn2();
        chk("perf_if_gnt",   perf_if_gnt,   32'd1);
        chk("perf_d_gnt",    perf_d_gnt,    32'd1);
        chk("perf_conflict", perf_conflict, 32'd1);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
